// File: rtl/instruction_decode.sv
// MIPS-subset ID stage: 32x32 register file, decoder, load-use hazard detection and one ID/EX register.
// Optional macro WB_BYPASS_EN forwards a same-cycle writeback onto the read ports.
module instruction_decode #(
  parameter logic [31:0] RF_RESET_VAL  = 32'h0000_0000,
  parameter int          BRANCH_CMP_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_instr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [31:0] out_rs_data,
  output logic [31:0] out_rt_data,
  output logic [31:0] out_imm,
  output logic [4:0]  out_dest,
  output logic [2:0]  out_alu_op,
  output logic        out_alu_src,
  output logic        out_mem_rd,
  output logic        out_mem_wr,
  output logic        out_reg_we,
  output logic        out_br_taken,
  output logic        out_illegal,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef struct packed {
    logic        valid;
    logic [2:0]  alu_op;
    logic        alu_src;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_we;
    logic        br_taken;
    logic        illegal;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
  } idex_t;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] rf [32];
  logic        uses_rt;
  logic        is_beq;
  logic        hazard;
  logic        accept;
  idex_t       dec;
  idex_t       idex_q;

  assign opcode = in_instr[31:26];
  assign rs     = in_instr[25:21];
  assign rt     = in_instr[20:16];
  assign rd     = in_instr[15:11];
  assign funct  = in_instr[5:0];

  // NOTE: the register file sits under the async reset because $1..$31 must come up
  // at RF_RESET_VAL; this forces flops instead of a RAM macro, which is acceptable at 32 entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        // NOTE: state is always assigned with <= so every flop samples pre-edge values.
        rf[i] <= (i == 0) ? 32'h0 : RF_RESET_VAL;
      end
    end else if (wb_we && wb_addr != 5'd0) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rs_val = rf[rs];
`ifdef WB_BYPASS_EN
    if (wb_we && wb_addr != 5'd0 && wb_addr == rs) rs_val = wb_data;
`endif
    if (rs == 5'd0) rs_val = 32'h0;
  end

  always_comb begin
    rt_val = rf[rt];
`ifdef WB_BYPASS_EN
    if (wb_we && wb_addr != 5'd0 && wb_addr == rt) rt_val = wb_data;
`endif
    if (rt == 5'd0) rt_val = 32'h0;
  end

  always_comb begin
    dec         = '0;
    dec.valid   = 1'b1;
    dec.imm     = {{16{in_instr[15]}}, in_instr[15:0]};
    dec.rs_data = rs_val;
    dec.rt_data = rt_val;
    uses_rt     = 1'b0;
    is_beq      = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        uses_rt    = 1'b1;
        dec.reg_we = 1'b1;
        dec.dest   = rd;
        case (funct)
          FN_ADD:  dec.alu_op = ALU_ADD;
          FN_SUB:  dec.alu_op = ALU_SUB;
          FN_AND:  dec.alu_op = ALU_AND;
          FN_OR:   dec.alu_op = ALU_OR;
          FN_SLT:  dec.alu_op = ALU_SLT;
          default: begin
            dec.illegal = 1'b1;
            dec.reg_we  = 1'b0;
            dec.dest    = 5'd0;
          end
        endcase
      end
      OP_LW: begin
        dec.alu_op  = ALU_ADD;
        dec.alu_src = 1'b1;
        dec.mem_rd  = 1'b1;
        dec.reg_we  = 1'b1;
        dec.dest    = rt;
      end
      OP_SW: begin
        uses_rt     = 1'b1;
        dec.alu_op  = ALU_ADD;
        dec.alu_src = 1'b1;
        dec.mem_wr  = 1'b1;
      end
      OP_BEQ: begin
        uses_rt    = 1'b1;
        is_beq     = 1'b1;
        dec.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        dec.alu_op  = ALU_ADD;
        dec.alu_src = 1'b1;
        dec.reg_we  = 1'b1;
        dec.dest    = rt;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.dest == 5'd0) dec.reg_we = 1'b0;
    dec.br_taken = (BRANCH_CMP_EN != 0) && is_beq && (rs_val == rt_val);
  end

  // Load-use: the load in ID/EX cannot supply its result to the instruction now in decode.
  assign hazard = idex_q.valid && idex_q.mem_rd && idex_q.dest != 5'd0 &&
                  (idex_q.dest == rs || (uses_rt && idex_q.dest == rt));

  assign in_ready = (!idex_q.valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q <= '0;
    end else if (accept) begin
      idex_q <= dec;
    end else if (hazard && out_ready) begin
      idex_q <= '0;
    end else if (out_ready) begin
      idex_q.valid <= 1'b0;
    end
  end

  assign out_valid    = idex_q.valid;
  assign out_alu_op   = idex_q.alu_op;
  assign out_alu_src  = idex_q.alu_src;
  assign out_mem_rd   = idex_q.mem_rd;
  assign out_mem_wr   = idex_q.mem_wr;
  assign out_reg_we   = idex_q.reg_we;
  assign out_br_taken = idex_q.br_taken;
  assign out_illegal  = idex_q.illegal;
  assign out_dest     = idex_q.dest;
  assign out_imm      = idex_q.imm;
  assign out_rs_data  = idex_q.rs_data;
  assign out_rt_data  = idex_q.rt_data;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: register file, decode, load-use bubble, stall, branch compare, bypass, reset.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] out_rs_data;
  logic [31:0] out_rt_data;
  logic [31:0] out_imm;
  logic [4:0]  out_dest;
  logic [2:0]  out_alu_op;
  logic        out_alu_src;
  logic        out_mem_rd;
  logic        out_mem_wr;
  logic        out_reg_we;
  logic        out_br_taken;
  logic        out_illegal;
  logic        out_valid;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;

  instruction_decode #(
    .RF_RESET_VAL (32'h0000_0007),
    .BRANCH_CMP_EN(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_instr    (in_instr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .out_rs_data (out_rs_data),
    .out_rt_data (out_rt_data),
    .out_imm     (out_imm),
    .out_dest    (out_dest),
    .out_alu_op  (out_alu_op),
    .out_alu_src (out_alu_src),
    .out_mem_rd  (out_mem_rd),
    .out_mem_wr  (out_mem_wr),
    .out_reg_we  (out_reg_we),
    .out_br_taken(out_br_taken),
    .out_illegal (out_illegal),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_op(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  logic [31:0] bypass_exp;

  initial begin
    rst_n     = 1'b0;
    in_instr  = 32'h0;
    in_valid  = 1'b0;
    wb_we     = 1'b0;
    wb_addr   = 5'd0;
    wb_data   = 32'h0;
    out_ready = 1'b1;
`ifdef WB_BYPASS_EN
    bypass_exp = 32'h0000_00AA;
`else
    bypass_exp = 32'h0000_0007;
`endif

    #12;
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_dest", {27'd0, out_dest}, 32'd0);
    check("reset_rs_data", out_rs_data, 32'd0);
    check("reset_imm", out_imm, 32'd0);
    check("reset_ctrl", {24'd0, out_alu_op, out_alu_src, out_mem_rd, out_mem_wr, out_reg_we, out_illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Writeback $5 then read it back through add $3,$5,$5.
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_1234;
    tick();
    wb_we = 1'b0;
    in_instr = r_op(5'd5, 5'd5, 5'd3, 6'h20); in_valid = 1'b1;
    tick();
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_rs_data", out_rs_data, 32'h1234);
    check("add_rt_data", out_rt_data, 32'h1234);
    check("add_alu_op", {29'd0, out_alu_op}, 32'd0);
    check("add_dest", {27'd0, out_dest}, 32'd3);
    check("add_reg_we", {31'd0, out_reg_we}, 32'd1);

    // Writes to $0 are dropped; sub with rd=$0 must not write.
    in_valid = 1'b0;
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
    tick();
    wb_we = 1'b0;
    in_instr = r_op(5'd0, 5'd1, 5'd0, 6'h22); in_valid = 1'b1;
    tick();
    check("r0_read", out_rs_data, 32'h0);
    check("rt_reset_val", out_rt_data, 32'h7);
    check("sub_alu_op", {29'd0, out_alu_op}, 32'd1);
    check("dest0_reg_we", {31'd0, out_reg_we}, 32'd0);

    // Remaining R-type ops.
    in_instr = r_op(5'd1, 5'd1, 5'd11, 6'h25);
    tick();
    check("or_alu_op", {29'd0, out_alu_op}, 32'd3);
    in_instr = r_op(5'd1, 5'd1, 5'd11, 6'h2A);
    tick();
    check("slt_alu_op", {29'd0, out_alu_op}, 32'd4);
    in_instr = r_op(5'd1, 5'd1, 5'd11, 6'h24);
    tick();
    check("and_alu_op", {29'd0, out_alu_op}, 32'd2);

    // Load-use: lw $4,8($0) then add $6,$4,$4.
    in_instr = i_op(6'h23, 5'd0, 5'd4, 16'd8);
    tick();
    check("lw_ctrl", {27'd0, out_alu_src, out_mem_rd, out_mem_wr, out_reg_we, out_valid}, 32'b11011);
    check("lw_dest", {27'd0, out_dest}, 32'd4);
    check("lw_imm", out_imm, 32'd8);
    in_instr = r_op(5'd4, 5'd4, 5'd6, 6'h20);
    #1;
    check("hazard_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("bubble_valid", {31'd0, out_valid}, 32'd0);
    check("bubble_mem_rd", {31'd0, out_mem_rd}, 32'd0);
    check("after_bubble_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("add_after_bubble_valid", {31'd0, out_valid}, 32'd1);
    check("add_after_bubble_dest", {27'd0, out_dest}, 32'd6);

    // Branch compare with $1=$1=7 and $0 vs $1.
    in_instr = i_op(6'h04, 5'd1, 5'd1, 16'hFFFC);
    tick();
    check("beq_taken", {31'd0, out_br_taken}, 32'd1);
    check("beq_imm", out_imm, 32'hFFFF_FFFC);
    check("beq_reg_we", {31'd0, out_reg_we}, 32'd0);
    in_instr = i_op(6'h04, 5'd0, 5'd1, 16'h0004);
    tick();
    check("beq_not_taken", {31'd0, out_br_taken}, 32'd0);

    // sw and addi.
    in_instr = i_op(6'h2B, 5'd0, 5'd5, 16'h0004);
    tick();
    check("sw_ctrl", {28'd0, out_alu_src, out_mem_rd, out_mem_wr, out_reg_we}, 32'b1010);
    in_instr = i_op(6'h08, 5'd1, 5'd10, 16'hFFFF);
    tick();
    check("addi_dest", {27'd0, out_dest}, 32'd10);
    check("addi_imm", out_imm, 32'hFFFF_FFFF);
    check("addi_ctrl", {29'd0, out_alu_src, out_mem_rd, out_reg_we}, 32'b101);

    // Same-cycle writeback of $2 while decoding or $1,$2,$0.
    wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'h0000_00AA;
    in_instr = r_op(5'd2, 5'd0, 5'd1, 6'h25);
    tick();
    wb_we = 1'b0;
    check("bypass_rs_data", out_rs_data, bypass_exp);
    tick();
    check("post_write_rs_data", out_rs_data, 32'hAA);

    // Stall: out_ready low for three cycles.
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    in_instr = r_op(5'd1, 5'd1, 5'd7, 6'h22); in_valid = 1'b1;
    tick();
    in_instr = r_op(5'd1, 5'd1, 5'd8, 6'h24);
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_dest", {27'd0, out_dest}, 32'd7);
      check("stall_alu_op", {29'd0, out_alu_op}, 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("released_dest", {27'd0, out_dest}, 32'd8);
    check("released_alu_op", {29'd0, out_alu_op}, 32'd2);

    // Illegal opcode.
    in_instr = i_op(6'h3F, 5'd1, 5'd2, 16'h0000);
    tick();
    check("illegal_flag", {31'd0, out_illegal}, 32'd1);
    check("illegal_ctrl", {29'd0, out_reg_we, out_mem_wr, out_mem_rd}, 32'd0);
    check("illegal_valid", {31'd0, out_valid}, 32'd1);

    // Reset pulse in the middle of a stall.
    out_ready = 1'b0;
    in_instr = r_op(5'd5, 5'd5, 5'd9, 6'h20);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midstall_reset_valid", {31'd0, out_valid}, 32'd0);
    check("midstall_reset_dest", {27'd0, out_dest}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_instr = r_op(5'd5, 5'd5, 5'd3, 6'h20);
    tick();
    check("post_reset_valid", {31'd0, out_valid}, 32'd1);
    check("post_reset_rf", out_rs_data, 32'h7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 SHALL have parameter RF_RESET_VAL, default 32'h0000_0000, value loaded into registers $1..$31 on reset.
REQ-002 SHALL have parameter BRANCH_CMP_EN, default 1: 1 resolves beq in this stage, 0 forces out_br_taken=0.
REQ-003 SHALL have port clk  input  1  rising-edge clock; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_instr  input  32  instruction word from fetch.
REQ-006 SHALL have port in_valid  input  1  in_instr is valid.
REQ-007 SHALL have port in_ready  output  1  stage accepts in_instr this cycle.
REQ-008 SHALL have ports wb_we input 1, wb_addr input 5, wb_data input 32: register-file write port.
REQ-009 SHALL have ports out_rs_data output 32, out_rt_data output 32, out_imm output 32 (sign-extended imm16), out_dest output 5.
REQ-010 SHALL have ports out_alu_op output 3, out_alu_src output 1, out_mem_rd output 1, out_mem_wr output 1, out_reg_we output 1, out_br_taken output 1, out_illegal output 1.
REQ-011 SHALL have ports out_valid output 1, out_ready input 1: downstream handshake.

Function
REQ-012 SHALL contain a 32x32 register file, two combinational read ports (rs=in_instr[25:21], rt=in_instr[20:16]), one write port committed on clk rising edge when wb_we=1.
REQ-013 SHALL ignore writes to $0; reads of $0 return 0.
REQ-014 SHALL register all out_* signals in a single ID/EX register; instruction accepted at edge N appears on outputs after edge N (latency 1 cycle).
REQ-015 SHALL accept an instruction on an edge where in_valid=1 and in_ready=1.
REQ-016 SHALL hold all out_* stable while out_valid=1 and out_ready=0; in_ready=0 in that case.
REQ-017 SHALL drive in_ready = (!out_valid | out_ready) & !hazard, combinationally.
REQ-018 SHALL assert hazard when out_valid=1, out_mem_rd=1, out_dest!=0 and out_dest equals incoming rs, or incoming rt for R-type/sw/beq.
REQ-019 SHALL, on hazard with out_ready=1, load a bubble (out_valid=0, all control outputs 0); incoming instruction accepted on the following edge.
REQ-020 SHALL clear out_valid on an edge where out_ready=1 and no instruction is accepted.
REQ-021 SHALL decode: opcode 0 funct add/sub/and/or/slt -> alu_op 0/1/2/3/4, reg_we=1, dest=rd; 0x23 lw -> add, alu_src=1, mem_rd=1, reg_we=1, dest=rt; 0x2B sw -> add, alu_src=1, mem_wr=1; 0x04 beq -> sub; 0x08 addi -> add, alu_src=1, reg_we=1, dest=rt.
REQ-022 SHALL treat any other opcode/funct as illegal: out_illegal=1, all write/memory controls 0, out_valid=1.
REQ-023 SHALL register out_br_taken = beq & (rs value == rt value), using the same read values as out_rs_data/out_rt_data.
REQ-024 SHALL force out_reg_we=0 whenever out_dest=0.
REQ-025 SHALL sign-extend in_instr[15:0] into out_imm (bit 15 replicated into 31:16).

Reset
REQ-026 SHALL, while rst_n=0, clear out_valid, all control outputs, out_dest, out_imm, out_rs_data, out_rt_data to 0, independent of clk.
REQ-027 SHALL set $0=0 and $1..$31=RF_RESET_VAL on reset.
REQ-028 SHALL discard any in-flight output on reset mid-handshake; first post-reset edge with in_valid=1 accepts normally.

Configuration
REQ-029 SHALL, with macro WB_BYPASS_EN defined, return wb_data on a read port when wb_we=1, wb_addr!=0 and wb_addr equals the read address in the same cycle.
REQ-030 SHALL, without WB_BYPASS_EN, return the pre-write register value in that case; the new value is visible from the next cycle.

Verification
REQ-031 SHALL cover: reset, write $5=0x1234 via wb, decode add $3,$5,$5 -> next cycle out_rs_data=out_rt_data=0x1234, alu_op=0, dest=3, reg_we=1.
REQ-032 SHALL cover: lw $4,8($0) then add $6,$4,$4 back-to-back -> one bubble cycle (out_valid=0), in_ready=0 one cycle, add issued next.
REQ-033 SHALL cover: out_ready=0 for 3 cycles with out_valid=1 -> outputs unchanged, in_ready=0, no instruction lost.
REQ-034 SHALL cover: beq $1,$1,-4 with RF_RESET_VAL=7 -> out_br_taken=1, out_imm=0xFFFFFFFC; beq $0,$1 -> out_br_taken=0.
REQ-035 SHALL cover: wb_we writing $2=0xAA in same cycle as decode of or $1,$2,$0 -> out_rs_data=0xAA with WB_BYPASS_EN, old value without.
REQ-036 SHALL cover: opcode 0x3F -> out_illegal=1, reg_we/mem_wr/mem_rd=0; rst_n pulse mid-stall -> out_valid=0 immediately.
